// File: rtl/cgra_pe_if.sv
`default_nettype none
// ============================================================================
// cgra_pe_if : switch and neighbour links of one CGRA processing element
// Rev 1.0
// ============================================================================
interface cgra_pe_if #(
  parameter int DW = 8
);
  logic [DW-1:0] sw_in;
  logic          sw_in_valid;
  logic [DW-1:0] sw_out;
  logic          sw_out_valid;
  logic [DW-1:0] next_out;
  logic          next_out_valid;
  logic [DW-1:0] prev_out;
  logic          prev_out_valid;
  logic [DW-1:0] next_in;
  logic          next_in_valid;
  logic [DW-1:0] prev_in;
  logic          prev_in_valid;

  // Environment side: the switch and the two neighbours.
  modport master (
    output sw_in, sw_in_valid, next_in, next_in_valid, prev_in, prev_in_valid,
    input  sw_out, sw_out_valid, next_out, next_out_valid, prev_out, prev_out_valid
  );

  // Processing element side.
  modport slave (
    input  sw_in, sw_in_valid, next_in, next_in_valid, prev_in, prev_in_valid,
    output sw_out, sw_out_valid, next_out, next_out_valid, prev_out, prev_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/cgra_pe.sv
`default_nettype none
// ============================================================================
// cgra_pe : packet-configured CGRA tile with weight bank, 6-op ALU and routing
// Rev 1.0
// ============================================================================
module cgra_pe #(
  parameter int DW = 8,
  parameter int NW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  cgra_pe_if.slave   pe
);
  localparam int c_iw = $clog2(NW);
  localparam int c_ww = DW - 2 - c_iw;

  localparam logic [1:0] c_hdr_weight = 2'b00;
  localparam logic [1:0] c_hdr_route  = 2'b01;
  localparam logic [1:0] c_hdr_start  = 2'b10;

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_and = 3'd1;
  localparam logic [2:0] c_op_or  = 3'd2;
  localparam logic [2:0] c_op_xor = 3'd3;
  localparam logic [2:0] c_op_max = 3'd4;
  localparam logic [2:0] c_op_mac = 3'd5;

  logic [c_ww-1:0] r_w [NW];
  logic [1:0]      r_route;
  logic [2:0]      r_op;
  logic            r_rot;
  logic [c_iw-1:0] r_wptr;
  logic [DW-1:0]   r_acc;
  logic [DW-1:0]   r_prev_lat;
  logic [DW-1:0]   r_next_lat;

  logic [DW-1:0]   r_sw_out;
  logic            r_sw_out_valid;
  logic [DW-1:0]   r_next_out;
  logic            r_next_out_valid;
  logic [DW-1:0]   r_prev_out;
  logic            r_prev_out_valid;

  logic [1:0]      w_hdr;
  logic [DW-1:0]   w_wext;
  logic [DW-1:0]   w_prod;
  logic [DW-1:0]   w_max_wp;
  logic [DW-1:0]   w_alu_res;
  logic            w_alu_ok;

  assign w_hdr    = pe.sw_in[DW-1:DW-2];
  assign w_wext   = {{(DW-c_ww){1'b0}}, r_w[r_wptr]};
  assign w_prod   = w_wext * r_prev_lat;
  assign w_max_wp = (w_wext > r_prev_lat) ? w_wext : r_prev_lat;

  always_comb begin
    w_alu_res = '0;
    w_alu_ok  = 1'b1;
    case (r_op)
      c_op_add: w_alu_res = w_wext + r_prev_lat + r_next_lat;
      c_op_and: w_alu_res = w_wext & r_prev_lat & r_next_lat;
      c_op_or:  w_alu_res = w_wext | r_prev_lat | r_next_lat;
      c_op_xor: w_alu_res = w_wext ^ r_prev_lat ^ r_next_lat;
      c_op_max: w_alu_res = (w_max_wp > r_next_lat) ? w_max_wp : r_next_lat;
      c_op_mac: w_alu_res = r_acc + w_prod;
      default:  w_alu_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) r_w[i] <= '0;
      r_route          <= 2'b00;
      r_op             <= c_op_add;
      r_rot            <= 1'b0;
      r_wptr           <= '0;
      r_acc            <= '0;
      r_prev_lat       <= '0;
      r_next_lat       <= '0;
      r_sw_out         <= '0;
      r_sw_out_valid   <= 1'b0;
      r_next_out       <= '0;
      r_next_out_valid <= 1'b0;
      r_prev_out       <= '0;
      r_prev_out_valid <= 1'b0;
    end else begin
      r_sw_out_valid   <= 1'b0;
      r_next_out_valid <= 1'b0;
      r_prev_out_valid <= 1'b0;

      // Latches update in parallel; a coincident local START sees the old value.
      if (pe.prev_in_valid) r_prev_lat <= pe.prev_in;
      if (pe.next_in_valid) r_next_lat <= pe.next_in;

      if (pe.sw_in_valid) begin
        if (w_hdr == c_hdr_weight) begin
          r_w[pe.sw_in[DW-3:DW-2-c_iw]] <= pe.sw_in[c_ww-1:0];
        end else if (w_hdr == c_hdr_route) begin
          r_route <= pe.sw_in[DW-3:DW-4];
          r_rot   <= pe.sw_in[DW-5];
          r_op    <= pe.sw_in[2:0];
          r_wptr  <= '0;
        end else if (r_route != 2'b00) begin
          if (r_route[0]) begin
            r_next_out       <= pe.sw_in;
            r_next_out_valid <= 1'b1;
          end
          if (r_route[1]) begin
            r_prev_out       <= pe.sw_in;
            r_prev_out_valid <= 1'b1;
          end
        end else if (w_hdr == c_hdr_start) begin
          if (w_alu_ok) begin
            r_sw_out       <= w_alu_res;
            r_sw_out_valid <= 1'b1;
            if (r_op == c_op_mac) r_acc <= w_alu_res;
            if (r_rot) r_wptr <= r_wptr + c_iw'(1);
          end
        end else begin
          r_sw_out       <= r_acc;
          r_sw_out_valid <= 1'b1;
          r_acc          <= '0;
          r_wptr         <= '0;
        end
      end
    end
  end

  assign pe.sw_out         = r_sw_out;
  assign pe.sw_out_valid   = r_sw_out_valid;
  assign pe.next_out       = r_next_out;
  assign pe.next_out_valid = r_next_out_valid;
  assign pe.prev_out       = r_prev_out;
  assign pe.prev_out_valid = r_prev_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_cgra_pe.sv
`default_nettype none
// ============================================================================
// tb_cgra_pe : directed self-checking bench for cgra_pe (DW=8, NW=4)
// Rev 1.0
// ============================================================================
module tb_cgra_pe;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  cgra_pe_if #(.DW(8)) bus ();

  cgra_pe #(.DW(8), .NW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pe    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Present one packet for one edge; outputs are sampled 1 time unit after it.
  task automatic send(input logic [7:0] pkt);
    bus.sw_in       = pkt;
    bus.sw_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sw_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic latch_neighbours(input logic [7:0] p, input logic [7:0] n);
    bus.prev_in       = p;
    bus.next_in       = n;
    bus.prev_in_valid = 1'b1;
    bus.next_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.prev_in_valid = 1'b0;
    bus.next_in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sw_out"},         bus.sw_out,                0);
    check({tag, ".sw_out_valid"},   {7'd0, bus.sw_out_valid},  0);
    check({tag, ".next_out"},       bus.next_out,              0);
    check({tag, ".next_out_valid"}, {7'd0, bus.next_out_valid},0);
    check({tag, ".prev_out"},       bus.prev_out,              0);
    check({tag, ".prev_out_valid"}, {7'd0, bus.prev_out_valid},0);
  endtask

  task automatic start_expect(input string tag, input logic [7:0] exp);
    send(8'h80);
    check({tag, ".data"},  bus.sw_out,               exp);
    check({tag, ".valid"}, {7'd0, bus.sw_out_valid}, 8'd1);
  endtask

  logic [7:0] rot_exp [5];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rot_exp[0] = 8'h35; rot_exp[1] = 8'h33; rot_exp[2] = 8'h30;
    rot_exp[3] = 8'h30; rot_exp[4] = 8'h35;

    // Reset held with random activity on every input.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.sw_in         = 8'($urandom);
      bus.sw_in_valid   = 1'b1;
      bus.prev_in       = 8'($urandom);
      bus.prev_in_valid = 1'b1;
      bus.next_in       = 8'($urandom);
      bus.next_in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check_all_zero("reset_hold");

    bus.sw_in_valid   = 1'b0;
    bus.prev_in_valid = 1'b0;
    bus.next_in_valid = 1'b0;
    bus.sw_in         = 8'h00;
    rst_n             = 1'b1;
    idle(3);
    check_all_zero("post_release_idle");

    // ADD
    send(8'h05);
    check("cfg_w0_no_strobe", {7'd0, bus.sw_out_valid}, 0);
    send(8'h13);
    bus.prev_in = 8'h10; bus.prev_in_valid = 1'b1;
    bus.next_in = 8'h20; bus.next_in_valid = 1'b1;
    send(8'h40);
    bus.prev_in_valid = 1'b0;
    bus.next_in_valid = 1'b0;
    check("cfg_route_no_strobe", {7'd0, bus.sw_out_valid}, 0);
    start_expect("add", 8'h35);
    idle(1);
    check("add_strobe_drop", {7'd0, bus.sw_out_valid}, 0);
    check("add_data_hold",   bus.sw_out, 8'h35);

    // Rotation through w0..w3 and wrap back to w0
    send(8'h48);
    for (int i = 0; i < 5; i++) start_expect($sformatf("rot%0d", i), rot_exp[i]);

    // No bypass: coincident prev_in is used only from the next packet
    send(8'h40);
    bus.prev_in = 8'h01; bus.prev_in_valid = 1'b1;
    start_expect("nobypass_old", 8'h35);
    bus.prev_in_valid = 1'b0;
    start_expect("nobypass_new", 8'h26);
    latch_neighbours(8'h10, 8'h20);

    // MAX and NOP
    send(8'h44);
    start_expect("max", 8'h20);
    send(8'h46);
    send(8'h80);
    check("nop_no_strobe", {7'd0, bus.sw_out_valid}, 0);
    check("nop_data_hold", bus.sw_out, 8'h20);

    // MAC with wrap, END drain, then accumulation restarts from zero
    send(8'h45);
    start_expect("mac0", 8'h50);
    start_expect("mac1", 8'hA0);
    start_expect("mac2", 8'hF0);
    start_expect("mac3", 8'h40);
    send(8'hC0);
    check("end_data",  bus.sw_out, 8'h40);
    check("end_valid", {7'd0, bus.sw_out_valid}, 1);
    start_expect("mac_after_end", 8'h50);

    // Forwarding to next only, then to both
    send(8'h50);
    send(8'h9A);
    check("fwd_next_data",   bus.next_out, 8'h9A);
    check("fwd_next_valid",  {7'd0, bus.next_out_valid}, 1);
    check("fwd_next_prev_v", {7'd0, bus.prev_out_valid}, 0);
    check("fwd_next_sw_v",   {7'd0, bus.sw_out_valid}, 0);
    send(8'h70);
    send(8'hC7);
    check("fwd_both_next", bus.next_out, 8'hC7);
    check("fwd_both_prev", bus.prev_out, 8'hC7);
    check("fwd_both_nv",   {7'd0, bus.next_out_valid}, 1);
    check("fwd_both_pv",   {7'd0, bus.prev_out_valid}, 1);
    check("fwd_both_sw_v", {7'd0, bus.sw_out_valid}, 0);
    idle(1);
    check("fwd_strobe_drop", {7'd0, bus.next_out_valid}, 0);

    // Forwarded END left acc alone: MAC continues from 0x50
    send(8'h45);
    start_expect("mac_after_fwd", 8'hA0);

    // Asynchronous reset coinciding with a local START
    bus.sw_in       = 8'h80;
    bus.sw_in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_immediate");
    @(posedge clk);
    #1;
    bus.sw_in_valid = 1'b0;
    check_all_zero("async_held");
    rst_n = 1'b1;
    idle(2);
    check("async_no_strobe", {7'd0, bus.sw_out_valid}, 0);

    // Weights, route and op back at reset values: ADD with w=0
    latch_neighbours(8'h10, 8'h20);
    start_expect("post_reset_add", 8'h30);
    send(8'h48);
    for (int i = 0; i < 4; i++) start_expect($sformatf("post_reset_w%0d", i), 8'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
